// File: rtl/mul_div_seq_pkg.sv
// Shared CPU package: FSM/op enums for the sequential multiply/divide unit,
// the CPU opcode and control-point types, and sizing constants.
package mul_div_seq_pkg;

  // Operand width and iteration count of the shift/add and restoring engines
  localparam int OPND_W     = 4;
  localparam int ITER_COUNT = 4;
  localparam int ITER_CNT_W = 2;
  localparam logic [ITER_CNT_W-1:0] ITER_LAST = ITER_CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_t;

  typedef enum logic [2:0] {
    OPC_NOP = 3'd0,
    OPC_ADD = 3'd1,
    OPC_SUB = 3'd2,
    OPC_MUL = 3'd3,
    OPC_DIV = 3'd4,
    OPC_LD  = 3'd5,
    OPC_ST  = 3'd6,
    OPC_BR  = 3'd7
  } opcode_t;

  typedef struct packed {
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   md_start;
    md_op_t md_op;
  } controlPts;

endpackage

// File: rtl/mul_div_dp.sv
// Datapath of the sequential multiply/divide unit.
// Ports: clock, reset_L (async active-low), load (capture operands),
// step (perform one iteration), op (0 MUL / 1 DIV), a, b (operands),
// step_result (combinational result after the current iteration:
// MUL product or {remainder, quotient}).
import mul_div_seq_pkg::*;

module mul_div_dp (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                load,
  input  logic                step,
  input  logic                op,
  input  logic [OPND_W-1:0]   a,
  input  logic [OPND_W-1:0]   b,
  output logic [2*OPND_W-1:0] step_result
);

  // hi: 9-bit accumulator (MUL) or 5-bit partial remainder (DIV, low bits)
  // lo: multiplier (MUL) or dividend shifting into quotient (DIV)
  // opnd: multiplicand (MUL) or divisor (DIV)
  logic [2*OPND_W:0]   hi;
  logic [OPND_W-1:0]   lo;
  logic [OPND_W-1:0]   opnd;
  logic                op_q;

  logic [2*OPND_W:0]   hi_next;
  logic [OPND_W-1:0]   lo_next;
  logic [2*OPND_W:0]   mul_sum;
  logic [OPND_W:0]     div_shift;
  logic [OPND_W+1:0]   div_diff;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    hi_next   = hi;
    lo_next   = lo;
    mul_sum   = {1'b0, hi[2*OPND_W-1:0]};
    div_shift = {hi[OPND_W-1:0], lo[OPND_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (md_op_t'(op_q) == OP_MUL) begin
      // Multiplicand enters at bit 4; carry lands in bit 8 before the shift
      if (lo[0]) begin
        mul_sum = {1'b0, hi[2*OPND_W-1:0]} + {1'b0, opnd, 4'h0};
      end else begin
        mul_sum = {1'b0, hi[2*OPND_W-1:0]};
      end
      hi_next = {1'b0, mul_sum[2*OPND_W:1]};
      lo_next = {mul_sum[0], lo[OPND_W-1:1]};
    end else begin
      // Sign bit of the 6-bit difference decides keep vs. restore
      if (div_diff[OPND_W+1] == 1'b0) begin
        hi_next = {4'h0, div_diff[OPND_W:0]};
        lo_next = {lo[OPND_W-2:0], 1'b1};
      end else begin
        hi_next = {4'h0, div_shift};
        lo_next = {lo[OPND_W-2:0], 1'b0};
      end
    end
  end

  // Result as it will stand after this iteration completes
  always_comb begin
    if (md_op_t'(op_q) == OP_MUL) begin
      step_result = hi_next[2*OPND_W-1:0];
    end else begin
      step_result = {hi_next[OPND_W-1:0], lo_next};
    end
  end

  // Operand capture and iteration registers
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      hi   <= 9'h000;
      lo   <= 4'h0;
      opnd <= 4'h0;
      op_q <= 1'b0;
    end else if (load) begin
      hi   <= 9'h000;
      op_q <= op;
      if (md_op_t'(op) == OP_MUL) begin
        lo   <= b;
        opnd <= a;
      end else begin
        lo   <= a;
        opnd <= b;
      end
    end else if (step) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential 4x4 unsigned multiply / divide unit with start/done handshake.
// Ports: clock, reset_L (async active-low), start, op (0 MUL / 1 DIV),
// a, b (operands), busy (ITER or DONE), done (one-cycle pulse),
// result (product or {remainder, quotient}), div_by_zero.
import mul_div_seq_pkg::*;

module mul_div_seq (
  input  logic                clock,
  input  logic                reset_L,
  input  logic                start,
  input  logic                op,
  input  logic [OPND_W-1:0]   a,
  input  logic [OPND_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*OPND_W-1:0] result,
  output logic                div_by_zero
);

  md_state_t               state;
  md_state_t               state_next;
  logic [ITER_CNT_W-1:0]   count;
  logic                    accept;
  logic                    div_zero_req;
  logic                    load;
  logic                    step;
  logic                    finish;
  logic [2*OPND_W-1:0]     step_result;

  // start is only honoured in IDLE; a zero divisor bypasses the iterations
  assign accept       = (state == ST_IDLE) && start;
  assign div_zero_req = accept && (md_op_t'(op) == OP_DIV) && (b == 4'h0);
  assign load         = accept && !div_zero_req;
  assign step         = (state == ST_ITER);
  assign finish       = step && (count == ITER_LAST);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  mul_div_dp u_dp (
    .clock       (clock),
    .reset_L     (reset_L),
    .load        (load),
    .step        (step),
    .op          (op),
    .a           (a),
    .b           (b),
    .step_result (step_result)
  );

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (div_zero_req) begin
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = ST_ITER;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (count == ITER_LAST) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ITER;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Iteration counter: cleared on acceptance, advances once per ITER edge
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count <= 2'd0;
    end else if (accept) begin
      count <= 2'd0;
    end else if (step) begin
      count <= count + 2'd1;
    end
  end

  // Result and divide-by-zero flag, held between operations
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      result      <= 8'h00;
      div_by_zero <= 1'b0;
    end else if (div_zero_req) begin
      result      <= {a, 4'hF};
      div_by_zero <= 1'b1;
    end else if (load) begin
      div_by_zero <= 1'b0;
    end else if (finish) begin
      result <= step_result;
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed self-checking bench for mul_div_seq.
module tb_mul_div_seq;

  logic       clock;
  logic       reset_L;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       div_by_zero;

  int checks;
  int passes;

  mul_div_seq dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one start at a negedge, scramble operands after acceptance, and
  // wait (bounded) for done. lat = number of posedges from the sampling edge
  // to the cycle showing done; 0 means no done seen. Ends at an IDLE negedge.
  task automatic run_op(input logic o, input logic [3:0] av, input logic [3:0] bv,
                        output int lat, output logic [7:0] res, output logic dbz);
    lat = 0;
    res = 8'h00;
    dbz = 1'b0;
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      a = ~av;
      b = 4'h0;
      op = ~o;
      if (done) begin
        lat = i;
        res = result;
        dbz = div_by_zero;
        break;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a = 4'h0;
    b = 4'h0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else passes++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else passes++;
    reset_L = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mul();
    int lat; logic [7:0] res; logic dbz;
    run_op(1'b0, 4'hD, 4'hB, lat, res, dbz);
    checks++; if (lat !== 5) $display("FAIL mul_db_latency: got %0d want 5", lat); else passes++;
    checks++; if (res !== 8'h8F) $display("FAIL mul_db_result: got %h want 8f", res); else passes++;
    checks++; if (dbz !== 1'b0) $display("FAIL mul_db_dbz: got %b want 0", dbz); else passes++;
    run_op(1'b0, 4'hF, 4'hF, lat, res, dbz);
    checks++; if (res !== 8'hE1) $display("FAIL mul_ff_result: got %h want e1", res); else passes++;
    repeat (3) @(negedge clock);
    checks++; if (result !== 8'hE1) $display("FAIL mul_hold_result: got %h want e1", result); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mul_idle_busy: got %b want 0", busy); else passes++;
    run_op(1'b0, 4'h0, 4'h9, lat, res, dbz);
    checks++; if (res !== 8'h00) $display("FAIL mul_09_result: got %h want 00", res); else passes++;
  endtask

  task automatic test_div();
    int lat; logic [7:0] res; logic dbz;
    run_op(1'b1, 4'hD, 4'h4, lat, res, dbz);
    checks++; if (lat !== 5) $display("FAIL div_d4_latency: got %0d want 5", lat); else passes++;
    checks++; if (res !== 8'h13) $display("FAIL div_d4_result: got %h want 13", res); else passes++;
    run_op(1'b1, 4'h3, 4'h7, lat, res, dbz);
    checks++; if (res !== 8'h30) $display("FAIL div_37_result: got %h want 30", res); else passes++;
    run_op(1'b1, 4'h7, 4'h0, lat, res, dbz);
    checks++; if (lat !== 1) $display("FAIL div0_latency: got %0d want 1", lat); else passes++;
    checks++; if (res !== 8'h7F) $display("FAIL div0_result: got %h want 7f", res); else passes++;
    checks++; if (dbz !== 1'b1) $display("FAIL div0_flag: got %b want 1", dbz); else passes++;
    repeat (3) @(negedge clock);
    checks++; if (div_by_zero !== 1'b1) $display("FAIL div0_flag_hold: got %b want 1", div_by_zero); else passes++;
    checks++; if (result !== 8'h7F) $display("FAIL div0_result_hold: got %h want 7f", result); else passes++;
    run_op(1'b1, 4'hD, 4'h4, lat, res, dbz);
    checks++; if (dbz !== 1'b0) $display("FAIL div_flag_clear: got %b want 0", dbz); else passes++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_at = 0;
    int second_at = 0;
    int bad_res = 0;
    start = 1'b1;
    op = 1'b0;
    a = 4'h2;
    b = 4'h3;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 12) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        if (result !== 8'h06) bad_res++;
      end
    end
    checks++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else passes++;
    checks++; if (second_at - first_at !== 6) $display("FAIL b2b_spacing: got %0d want 6", second_at - first_at); else passes++;
    checks++; if (first_at !== 5) $display("FAIL b2b_first: got %0d want 5", first_at); else passes++;
    checks++; if (bad_res !== 0) $display("FAIL b2b_result: got %0d bad results want 0", bad_res); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] res; logic dbz;
    int pulses = 0;
    start = 1'b1;
    op = 1'b0;
    a = 4'h2;
    b = 4'h3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL midrst_result: got %h want 00", result); else passes++;
    @(negedge clock);
    reset_L = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); else passes++;
    checks++; if (result !== 8'h00) $display("FAIL midrst_result_after: got %h want 00", result); else passes++;
    run_op(1'b0, 4'h5, 4'h5, lat, res, dbz);
    checks++; if (lat !== 5) $display("FAIL midrst_next_latency: got %0d want 5", lat); else passes++;
    checks++; if (res !== 8'h19) $display("FAIL midrst_next_result: got %h want 19", res); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 The block SHALL have the following ports:
- clock  in  1  system clock, rising-edge active.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  request from the CPU control FSM; sampled only in IDLE.
- op  in  1  0 = MUL (unsigned a*b), 1 = DIV (unsigned a/b).
- a  in  4  operand A (multiplicand / dividend).
- b  in  4  operand B (multiplier / divisor).
- busy  out  1  high while an operation is in progress (ITER or DONE).
- done  out  1  single-cycle completion pulse to the control FSM.
- result  out  8  MUL: product; DIV: {remainder[3:0], quotient[3:0]}.
- div_by_zero  out  1  high with done when op=DIV and b=0.

Function
REQ-002 The block SHALL implement the FSM states IDLE, ITER and DONE.
REQ-003 In IDLE with start=1 at a rising edge, the block SHALL latch a, b and op, clear the iteration counter, and go to ITER; the exception is op=DIV with b=0, which SHALL go directly to DONE.
REQ-004 In IDLE with start=0, the block SHALL stay in IDLE and hold result and div_by_zero.
REQ-005 The block SHALL remain in ITER for exactly 4 clock edges, performing one iteration per edge with a 2-bit counter running 0..3; on the edge where the counter equals 3, it SHALL go to DONE.
REQ-006 MUL iteration: shift-add on the LSB of the multiplier; if the LSB is 1, the multiplicand aligned to bit 4 SHALL be added into an 8-bit accumulator, then {acc, multiplier} SHALL shift right by 1; the carry-out is kept in a 9th accumulator bit.
REQ-007 DIV iteration: restoring division; {rem, dividend} SHALL shift left by 1, the divisor SHALL be trial-subtracted from the 5-bit partial remainder, and a non-negative difference SHALL be kept with quotient bit 1, otherwise the remainder is restored with quotient bit 0.
REQ-008 DONE SHALL last exactly one cycle: done=1, result valid, then the block unconditionally returns to IDLE.
REQ-009 Latency: start sampled at edge E0 gives done=1 in the cycle after E4 (5 cycles). For divide-by-zero, done=1 in the cycle after E0.
REQ-010 Divide-by-zero: result SHALL be {a, 4'hF} and div_by_zero SHALL be 1; div_by_zero SHALL stay valid until the next accepted start.
REQ-011 result SHALL hold its last value from DONE until the next accepted start; it is not cleared by returning to IDLE.
REQ-012 start asserted while busy=1 (in ITER or DONE) SHALL be ignored and SHALL NOT be queued.
REQ-013 Operand changes on a, b or op after acceptance SHALL NOT affect the operation in progress.
REQ-014 busy SHALL be 0 in IDLE and 1 in ITER and DONE; done SHALL be 1 only in DONE.
REQ-015 All outputs SHALL be driven from registers or from state decode only; there SHALL be no combinational path from start to done.

Reset
REQ-016 reset_L low SHALL immediately force IDLE, counter=0, result=8'h00, div_by_zero=0, busy=0, done=0.
REQ-017 Reset asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-018 After reset deassertion, the first start SHALL be accepted normally.

Structure
REQ-019 The state enum (IDLE/ITER/DONE) and the op enum (MUL/DIV) SHALL live in the shared CPU package, alongside opcode_t and controlPts.
REQ-020 The datapath SHALL be a sub-module mul_div_dp (accumulator/remainder registers, adder/subtractor, shifters); mul_div_seq SHALL hold the FSM, the counter and the handshake.
REQ-021 The iteration count (4) and operand width (4) SHALL be package constants.

Verification
REQ-022 MUL a=4'hD, b=4'hB -> done in the 5th cycle after start, result=8'h8F, div_by_zero=0.
REQ-023 MUL a=4'hF, b=4'hF -> result=8'hE1; MUL a=4'h0, b=4'h9 -> result=8'h00.
REQ-024 DIV a=4'hD, b=4'h4 -> result=8'h13 (r=1, q=3); DIV a=4'h3, b=4'h7 -> result=8'h30.
REQ-025 DIV a=4'h7, b=4'h0 -> done in the cycle after start, result=8'h7F, div_by_zero=1.
REQ-026 start pulsed every cycle for 12 cycles with MUL 2*3 -> exactly 2 done pulses (one every 6 cycles), each with result=8'h06.
REQ-027 reset_L low during the 2nd ITER cycle -> no done pulse, result=8'h00; a following MUL 5*5 -> result=8'h19.
